// File: rtl/tx_pause_gen_pkg.sv
// Shared MAC-control PAUSE constants and wire byte-order helper, common to the tx
// generator and rx pause/DA detection.
package tx_pause_gen_pkg;

  localparam logic [47:0] PAUSE_DA     = 48'h0180C2000001;
  localparam logic [15:0] PAUSE_TYPE   = 16'h8808;
  localparam logic [15:0] PAUSE_OPCODE = 16'h0001;

  localparam int unsigned NUM_WORDS = 8;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned BE_W      = 8;

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);
  localparam logic [BE_W-1:0]  BE_FULL   = 8'hFF;
  localparam logic [BE_W-1:0]  BE_LAST   = 8'h0F;

  // Byte idx of a 48-bit address in wire order; idx 0 = [47:40] goes out first.
  function automatic logic [7:0] wire_byte(input logic [47:0] addr, input logic [2:0] idx);
    return 8'(addr >> (6'd40 - {idx, 3'b000}));
  endfunction

endpackage

// File: rtl/tx_pause_word_mux.sv
// Combinational PAUSE frame word builder: word index, quanta and SA -> data and byte enables.
// Lane 0 (bits [7:0]) carries the earliest byte on the wire.
module tx_pause_word_mux
  import tx_pause_gen_pkg::*;
(
  input  logic [CNT_W-1:0]  i_word_cnt,
  input  logic [15:0]       i_quanta,
  input  logic [47:0]       i_mac,
  output logic [DATA_W-1:0] o_data_c,
  output logic [BE_W-1:0]   o_be_c
);

  always_comb begin
    o_data_c = '0;
    o_be_c   = (i_word_cnt == LAST_WORD) ? BE_LAST : BE_FULL;
    case (i_word_cnt)
      3'd0: o_data_c = {wire_byte(i_mac, 3'd1), wire_byte(i_mac, 3'd0),
                        wire_byte(PAUSE_DA, 3'd5), wire_byte(PAUSE_DA, 3'd4),
                        wire_byte(PAUSE_DA, 3'd3), wire_byte(PAUSE_DA, 3'd2),
                        wire_byte(PAUSE_DA, 3'd1), wire_byte(PAUSE_DA, 3'd0)};
      3'd1: o_data_c = {PAUSE_OPCODE[7:0], PAUSE_OPCODE[15:8],
                        PAUSE_TYPE[7:0], PAUSE_TYPE[15:8],
                        wire_byte(i_mac, 3'd5), wire_byte(i_mac, 3'd4),
                        wire_byte(i_mac, 3'd3), wire_byte(i_mac, 3'd2)};
      3'd2: o_data_c = {48'h0, i_quanta[7:0], i_quanta[15:8]};
      default: o_data_c = '0;
    endcase
  end

endmodule

// File: rtl/tx_pause_gen.sv
// Transmit PAUSE frame generator: on request emits one 60-byte MAC-control PAUSE frame
// as 8 x 64-bit words over a valid/ack handshake, with a single-deep pending request.
module tx_pause_gen
  import tx_pause_gen_pkg::*;
(
  input  logic              txclk,
  input  logic              reset,
  input  logic              pause_req,
  input  logic [15:0]       pause_quanta,
  input  logic [47:0]       MAC_Addr,
  input  logic              pause_ack,
  output logic              pause_valid,
  output logic [DATA_W-1:0] pause_data,
  output logic [BE_W-1:0]   pause_be,
  output logic              pause_sof,
  output logic              pause_eof,
  output logic              pause_busy
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_pending;
  logic [15:0]        r_quanta;
  logic [47:0]        r_mac;
  logic               r_valid;
  logic [DATA_W-1:0]  r_data;
  logic [BE_W-1:0]    r_be;
  logic               r_sof;
  logic               r_eof;
  logic               r_busy;

  logic               w_adv;
  logic               w_last;
  logic               w_start;
  logic               w_load;
  logic [CNT_W-1:0]   w_sel_cnt;
  logic [15:0]        w_sel_quanta;
  logic [47:0]        w_sel_mac;
  logic [DATA_W-1:0]  w_mux_data;
  logic [BE_W-1:0]    w_mux_be;

  // A new frame starts from IDLE, or back-to-back when the eof word is accepted
  // with a request pending or arriving in the same cycle.
  assign w_adv        = r_valid & pause_ack;
  assign w_last       = (r_cnt == LAST_WORD);
  assign w_start      = (r_state == S_IDLE) ? pause_req
                                            : (w_adv & w_last & (r_pending | pause_req));
  assign w_load       = w_start | (w_adv & ~w_last);
  assign w_sel_cnt    = w_start ? '0 : CNT_W'(r_cnt + 1'b1);
  assign w_sel_quanta = w_start ? pause_quanta : r_quanta;
  assign w_sel_mac    = w_start ? MAC_Addr : r_mac;

  tx_pause_word_mux u_word_mux (
    .i_word_cnt (w_sel_cnt),
    .i_quanta   (w_sel_quanta),
    .i_mac      (w_sel_mac),
    .o_data_c   (w_mux_data),
    .o_be_c     (w_mux_be)
  );

  always_ff @(posedge txclk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_quanta  <= '0;
      r_mac     <= '0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_be      <= '0;
      r_sof     <= 1'b0;
      r_eof     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pending <= 1'b0;
        end
        S_SEND: begin
          // A restart consumes the pending slot; a request in that same cycle refills it.
          r_pending <= w_start ? (r_pending & pause_req) : (r_pending | pause_req);
        end
        default: r_pending <= 1'b0;
      endcase

      if (w_load) begin
        r_state  <= S_SEND;
        r_cnt    <= w_sel_cnt;
        r_quanta <= w_sel_quanta;
        r_mac    <= w_sel_mac;
        r_valid  <= 1'b1;
        r_data   <= w_mux_data;
        r_be     <= w_mux_be;
        r_sof    <= w_start;
        r_eof    <= (w_sel_cnt == LAST_WORD);
        r_busy   <= 1'b1;
      end else if (w_adv) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_valid <= 1'b0;
        r_data  <= '0;
        r_be    <= '0;
        r_sof   <= 1'b0;
        r_eof   <= 1'b0;
        r_busy  <= 1'b0;
      end
    end
  end

  assign pause_valid = r_valid;
  assign pause_data  = r_data;
  assign pause_be    = r_be;
  assign pause_sof   = r_sof;
  assign pause_eof   = r_eof;
  assign pause_busy  = r_busy;

endmodule
